// File: rtl/jtpang_objdma.sv
// rtl/jtpang_objdma.sv - Pang object attribute table DMA engine
//
// Takes the Z80 bus on a rising edge of dma_go and copies 2**AW bytes starting
// at VRAM byte SRC_BASE into the object RAM. It then returns the bus.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   cen             CPU clock enable; one byte is moved per cen once settled
//   LVBL            vertical blank (active low), used only with the macro below
//   dma_go          CPU I/O strobe level; its rising edge requests a transfer
//   busrq_n/busak_n Z80 bus request / acknowledge handshake
//   dma_cs          high while this block owns VRAM
//   dma_addr        VRAM byte address (SRC_BASE + cnt)
//   dma_din         VRAM read data, one clk latency
//   obj_addr/obj_din/obj_we  object RAM write port
//   dma_busy        request accepted and not yet back in IDLE
//
// Configuration macro: JTPANG_DMA_VBLANK_EN - when defined, a pending request
// leaves IDLE only while LVBL is low.
module jtpang_objdma #(
   parameter int          AW       = 9,
   parameter logic [11:0] SRC_BASE = 12'hE00
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          LVBL,
   input  logic          dma_go,
   output logic          busrq_n,
   input  logic          busak_n,
   output logic          dma_cs,
   output logic [11:0]   dma_addr,
   input  logic [7:0]    dma_din,
   output logic [AW-1:0] obj_addr,
   output logic [7:0]    obj_din,
   output logic          obj_we,
   output logic          dma_busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] COPY = 2'd2;
   localparam logic [1:0] REL  = 2'd3;

   localparam logic [AW-1:0] LAST = '1;

   logic [1:0]    state;
   logic          pend;
   logic          go_l;
   logic          settled;
   logic [AW-1:0] cnt;
   logic          rise;
   logic          vb_ok;
   logic          leave;

   assign rise = dma_go & ~go_l;

`ifdef JTPANG_DMA_VBLANK_EN
   assign vb_ok = ~LVBL;
`else
   logic unused_lvbl;
   assign unused_lvbl = LVBL;
   assign vb_ok       = 1'b1;
`endif

   assign leave    = (state == IDLE) & pend & vb_ok;
   assign dma_addr = SRC_BASE + 12'(cnt);
   assign dma_busy = (state != IDLE) | pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pend     <= 1'b0;
         go_l     <= 1'b0;
         settled  <= 1'b0;
         cnt      <= '0;
         busrq_n  <= 1'b1;
         dma_cs   <= 1'b0;
         obj_we   <= 1'b0;
         obj_addr <= '0;
         obj_din  <= 8'd0;
      end else begin
         go_l   <= dma_go;
         obj_we <= 1'b0;
         // A new edge in the same clk that consumes pend queues a fresh request.
         if (rise)
            pend <= 1'b1;
         else if (leave)
            pend <= 1'b0;

         case (state)
            IDLE: begin
               busrq_n <= 1'b1;
               dma_cs  <= 1'b0;
               if (leave) begin
                  state   <= REQ;
                  busrq_n <= 1'b0;
               end
            end
            REQ: begin
               if (!busak_n) begin
                  state   <= COPY;
                  dma_cs  <= 1'b1;
                  cnt     <= '0;
                  settled <= 1'b0;
               end
            end
            COPY: begin
               if (busak_n) begin
                  // Bus taken back early: stop without writing any further byte.
                  state  <= REL;
                  dma_cs <= 1'b0;
               end else if (cen && settled) begin
                  obj_we   <= 1'b1;
                  obj_addr <= cnt;
                  obj_din  <= dma_din;
                  cnt      <= cnt + 1'b1;
                  settled  <= 1'b0;
                  if (cnt == LAST) begin
                     state  <= REL;
                     dma_cs <= 1'b0;
                  end
               end else begin
                  // VRAM data for the current address is valid one clk later.
                  settled <= 1'b1;
               end
            end
            REL: begin
               busrq_n <= 1'b1;
               dma_cs  <= 1'b0;
               if (busak_n)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
